// File: rtl/systolic_feeder.sv
// systolic_feeder: operand buffers for A and B plus the wavefront sequencer
// that clears the systolic array, streams skewed rows/columns into it and
// flags completion. Every output is registered.
`timescale 1ns/1ps
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int A_ROWS     = 2,
  parameter int A_COLS     = 2,
  parameter int B_COLS     = 2,
  localparam int ROW_MAX   = (A_ROWS > A_COLS) ? A_ROWS : A_COLS,
  localparam int COL_MAX   = (A_COLS > B_COLS) ? A_COLS : B_COLS,
  localparam int ROW_W     = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1,
  localparam int COL_W     = (COL_MAX > 1) ? $clog2(COL_MAX) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [ROW_W-1:0]      wr_row,
  input  logic [COL_W-1:0]      wr_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  arr_clr,
  output logic [DATA_WIDTH-1:0] a_out [A_ROWS],
  output logic [DATA_WIDTH-1:0] b_out [B_COLS],
  output logic                  done
);

  // Feed length: the last element enters the far corner PE after this many cycles.
  localparam int FEED_LEN = A_COLS + A_ROWS + B_COLS - 2;
  localparam int CNT_W    = (FEED_LEN > 0) ? $clog2(FEED_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FEED_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_FEED  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   a_buf [A_ROWS][A_COLS];
  logic [DATA_WIDTH-1:0]   b_buf [A_COLS][B_COLS];
  logic [DATA_WIDTH-1:0]   a_nxt [A_ROWS];
  logic [DATA_WIDTH-1:0]   b_nxt [B_COLS];

  // State and feed counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: one clear cycle, FEED_LEN feed cycles, one done cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: begin
        state_nxt = S_FEED;
        cnt_nxt   = '0;
      end
      S_FEED: begin
        if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand buffers: writable only while idle. Matching against constant
  // loop indices means out-of-range addresses simply hit no element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < A_ROWS; r++)
        for (int c = 0; c < A_COLS; c++)
          a_buf[r][c] <= '0;
      for (int r = 0; r < A_COLS; r++)
        for (int c = 0; c < B_COLS; c++)
          b_buf[r][c] <= '0;
    end else if (wr_en && (state == S_IDLE)) begin
      for (int r = 0; r < A_ROWS; r++)
        for (int c = 0; c < A_COLS; c++)
          if (!wr_sel && (int'(wr_row) == r) && (int'(wr_col) == c))
            a_buf[r][c] <= wr_data;
      for (int r = 0; r < A_COLS; r++)
        for (int c = 0; c < B_COLS; c++)
          if (wr_sel && (int'(wr_row) == r) && (int'(wr_col) == c))
            b_buf[r][c] <= wr_data;
    end
  end

  // Skewed wavefront for the upcoming cycle: lane i carries element t-i.
  // Signed int arithmetic keeps negative offsets from matching any element.
  always_comb begin
    for (int i = 0; i < A_ROWS; i++) begin
      a_nxt[i] = '0;
      if (state_nxt == S_FEED)
        for (int k = 0; k < A_COLS; k++)
          if ((int'(cnt_nxt) - i) == k) a_nxt[i] = a_buf[i][k];
    end
    for (int j = 0; j < B_COLS; j++) begin
      b_nxt[j] = '0;
      if (state_nxt == S_FEED)
        for (int k = 0; k < A_COLS; k++)
          if ((int'(cnt_nxt) - j) == k) b_nxt[j] = b_buf[k][j];
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      arr_clr <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < A_ROWS; i++) a_out[i] <= '0;
      for (int j = 0; j < B_COLS; j++) b_out[j] <= '0;
    end else begin
      busy    <= (state_nxt != S_IDLE);
      arr_clr <= (state_nxt == S_CLEAR);
      done    <= (state_nxt == S_DONE);
      for (int i = 0; i < A_ROWS; i++) a_out[i] <= a_nxt[i];
      for (int j = 0; j < B_COLS; j++) b_out[j] <= b_nxt[j];
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: default 2x2x2 instance with randomized
// operands against a matrix-level model, plus a 3x2x1 instance for the
// non-square and out-of-range cases.
`timescale 1ns/1ps
module tb_systolic_feeder;

  localparam int DW = 8;
  localparam int T  = 4;

  logic clk;
  logic rst_n;

  // default instance signals
  logic          start, wr_en, wr_sel;
  logic [0:0]    wr_row, wr_col;
  logic [DW-1:0] wr_data;
  logic          busy, arr_clr, done;
  logic [DW-1:0] a_out [2];
  logic [DW-1:0] b_out [2];

  // non-square instance signals
  logic          ns_start, ns_wr_en, ns_wr_sel;
  logic [1:0]    ns_wr_row;
  logic [0:0]    ns_wr_col;
  logic [DW-1:0] ns_wr_data;
  logic          ns_busy, ns_arr_clr, ns_done;
  logic [DW-1:0] ns_a_out [3];
  logic [DW-1:0] ns_b_out [1];

  int n_cmp = 0;
  int n_bad = 0;

  // operand model: what the buffers should hold
  int ref_a [2][2];
  int ref_b [2][2];

  systolic_feeder #(.DATA_WIDTH(DW), .A_ROWS(2), .A_COLS(2), .B_COLS(2)) dut (
    .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy),
    .arr_clr(arr_clr), .a_out(a_out), .b_out(b_out), .done(done));

  systolic_feeder #(.DATA_WIDTH(DW), .A_ROWS(3), .A_COLS(2), .B_COLS(1)) dut_ns (
    .clk(clk), .reset(rst_n), .wr_en(ns_wr_en), .wr_sel(ns_wr_sel), .wr_row(ns_wr_row),
    .wr_col(ns_wr_col), .wr_data(ns_wr_data), .start(ns_start), .busy(ns_busy),
    .arr_clr(ns_arr_clr), .a_out(ns_a_out), .b_out(ns_b_out), .done(ns_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_a(input int i, input int t);
    int d = t - i;
    return (d >= 0 && d < 2) ? ref_a[i][d] : 0;
  endfunction

  function automatic int exp_b(input int j, input int t);
    int d = t - j;
    return (d >= 0 && d < 2) ? ref_b[d][j] : 0;
  endfunction

  task automatic clear_ref();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        ref_a[r][c] = 0;
        ref_b[r][c] = 0;
      end
  endtask

  task automatic wr(input bit sel, input int row, input int col, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_row = 1'(row); wr_col = 1'(col); wr_data = DW'(data);
    tick();
    wr_en = 1'b0;
    if (sel) ref_b[row][col] = data; else ref_a[row][col] = data;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " clr"}, arr_clr, 0);
    check({tag, " done"}, done, 0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s a%0d", tag, i), a_out[i], 0);
      check($sformatf("%s b%0d", tag, i), b_out[i], 0);
    end
  endtask

  // One full run on the default instance. abort_t >= 0 pulls reset at that feed cycle.
  task automatic run(input string tag, input int abort_t, input bit lock_wr, input bit same_wr);
    int ah [2][T];
    int bh [2][T];
    int r, c, v, acc, expc, sa, sb;
    bit s;
    start = 1'b1;
    if (same_wr) begin
      s = 1'($urandom_range(1)); r = $urandom_range(1); c = $urandom_range(1);
      v = $urandom_range(255);
      wr_en = 1'b1; wr_sel = s; wr_row = 1'(r); wr_col = 1'(c); wr_data = DW'(v);
      if (s) ref_b[r][c] = v; else ref_a[r][c] = v;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    // clear cycle
    check({tag, " clr"}, arr_clr, 1);
    check({tag, " clr busy"}, busy, 1);
    check({tag, " clr done"}, done, 0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s clr a%0d", tag, i), a_out[i], 0);
      check($sformatf("%s clr b%0d", tag, i), b_out[i], 0);
    end
    for (int t = 0; t < T; t++) begin
      if (lock_wr) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 1'b0; wr_col = 1'b0; wr_data = 8'd9;
      end
      start = 1'($urandom_range(1));
      tick();
      check($sformatf("%s t%0d busy", tag, t), busy, 1);
      check($sformatf("%s t%0d clr", tag, t), arr_clr, 0);
      check($sformatf("%s t%0d done", tag, t), done, 0);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("%s t%0d a%0d", tag, t, i), a_out[i], exp_a(i, t));
        check($sformatf("%s t%0d b%0d", tag, t, i), b_out[i], exp_b(i, t));
        ah[i][t] = int'(a_out[i]);
        bh[i][t] = int'(b_out[i]);
      end
      if (t == abort_t) begin
        start = 1'b0; wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle_zero({tag, " async rst"});
        clear_ref();
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        return;
      end
    end
    start = 1'b0; wr_en = 1'b0;
    tick();
    check({tag, " done"}, done, 1);
    check({tag, " done busy"}, busy, 1);
    check({tag, " done clr"}, arr_clr, 0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s done a%0d", tag, i), a_out[i], 0);
      check($sformatf("%s done b%0d", tag, i), b_out[i], 0);
    end
    tick();
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle done"}, done, 0);
    // PE(i,j) sees lane a[i] delayed by j and lane b[j] delayed by i
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = 0; expc = 0;
        for (int st = 0; st < T + 2; st++) begin
          sa = st - j; sb = st - i;
          if (sa >= 0 && sa < T && sb >= 0 && sb < T) acc += ah[i][sa] * bh[j][sb];
        end
        for (int k = 0; k < 2; k++) expc += ref_a[i][k] * ref_b[k][j];
        check($sformatf("%s c%0d%0d", tag, i, j), acc, expc);
      end
  endtask

  int na [4][3] = '{'{1, 0, 0}, '{2, 3, 0}, '{0, 4, 5}, '{0, 0, 6}};
  int nb [4]    = '{7, 8, 0, 0};

  task automatic ns_wr(input bit sel, input int row, input int col, input int data);
    ns_wr_en = 1'b1; ns_wr_sel = sel; ns_wr_row = 2'(row); ns_wr_col = 1'(col);
    ns_wr_data = DW'(data);
    tick();
    ns_wr_en = 1'b0;
  endtask

  initial begin
    int p;
    rst_n = 1'b0;
    start = 0; wr_en = 0; wr_sel = 0; wr_row = 0; wr_col = 0; wr_data = 0;
    ns_start = 0; ns_wr_en = 0; ns_wr_sel = 0; ns_wr_row = 0; ns_wr_col = 0; ns_wr_data = 0;
    clear_ref();
    tick(); tick();
    check_idle_zero("reset");
    check("reset ns busy", ns_busy, 0);
    rst_n = 1'b1;
    tick();

    // directed 2x2 product: every c element is 5
    wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 1, 0, 1); wr(0, 1, 1, 2);
    wr(1, 0, 0, 1); wr(1, 0, 1, 1); wr(1, 1, 0, 2); wr(1, 1, 1, 2);
    run("dir", -1, 0, 0);

    // writes during a run are dropped; the following run sees the old data
    run("lock", -1, 1, 0);
    run("after_lock", -1, 0, 0);

    // randomized operands, some with a write on the start edge
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          wr(0, r, c, $urandom_range(255));
          wr(1, r, c, $urandom_range(255));
        end
      run($sformatf("rnd%0d", n), -1, 0, 1'($urandom_range(1)));
    end

    // start held high: period is clear + T feed + done + one idle cycle
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      p = (k - 1) % (T + 3);
      check($sformatf("hold k%0d clr", k), arr_clr, (p == 0));
      check($sformatf("hold k%0d done", k), done, (p == T + 1));
      check($sformatf("hold k%0d busy", k), busy, (p != T + 2));
      check($sformatf("hold k%0d a0", k), a_out[0], (p >= 1 && p <= T) ? exp_a(0, p - 1) : 0);
      check($sformatf("hold k%0d b1", k), b_out[1], (p >= 1 && p <= T) ? exp_b(1, p - 1) : 0);
    end
    start = 1'b0;
    tick();
    check("hold end busy", busy, 0);
    tick();
    check("hold end clr", arr_clr, 0);

    // reset mid-feed, then the cleared buffers give an all-zero feed
    run("rst_mid", 1, 0, 0);
    run("post_rst", -1, 0, 0);

    // non-square 3x2 by 2x1 with ignored out-of-range writes
    ns_wr(0, 0, 0, 1); ns_wr(0, 0, 1, 2); ns_wr(0, 1, 0, 3);
    ns_wr(0, 1, 1, 4); ns_wr(0, 2, 0, 5); ns_wr(0, 2, 1, 6);
    ns_wr(1, 0, 0, 7); ns_wr(1, 1, 0, 8);
    ns_wr(1, 2, 0, 7); ns_wr(1, 0, 1, 9); ns_wr(0, 3, 0, 7); ns_wr(1, 3, 1, 9);
    ns_start = 1'b1;
    tick();
    ns_start = 1'b0;
    check("ns clr", ns_arr_clr, 1);
    check("ns clr busy", ns_busy, 1);
    for (int t = 0; t < T; t++) begin
      tick();
      check($sformatf("ns t%0d clr", t), ns_arr_clr, 0);
      check($sformatf("ns t%0d done", t), ns_done, 0);
      for (int i = 0; i < 3; i++)
        check($sformatf("ns t%0d a%0d", t, i), ns_a_out[i], na[t][i]);
      check($sformatf("ns t%0d b0", t), ns_b_out[0], nb[t]);
    end
    tick();
    check("ns done", ns_done, 1);
    check("ns done b0", ns_b_out[0], 0);
    tick();
    check("ns idle busy", ns_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
